// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: request sizes,
// memory write modes and the sequencing states.
package dm_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] DM_MODE_WORD = 2'b00;
    localparam logic [1:0] DM_MODE_HALF = 2'b01;
    localparam logic [1:0] DM_MODE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // Size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_W : size;
    endfunction

    function automatic logic [1:0] size_to_mode(input logic [1:0] size);
        case (size)
            SIZE_B:  return DM_MODE_BYTE;
            SIZE_H:  return DM_MODE_HALF;
            default: return DM_MODE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from a word,
// and merges a right-aligned store lane into a word for read-modify-write.
module lsu_lane_align
    import dm_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            is_signed,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] store_lane;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        load_data = shifted;
        case (size)
            SIZE_B:  load_data = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        case (size)
            SIZE_B:  lane_mask = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
            SIZE_H:  lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
            default: lane_mask = '1;
        endcase
    end

    assign store_lane = wdata << shamt;
    assign merged     = (word & ~lane_mask) | (store_lane & lane_mask);

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator between the MEM stage and the data memory port.
// Sub-word stores at non-zero lane offsets are done as read-modify-write.
//
// state  | meaning
// IDLE   | ready for a request; dm_addr holds the last index
// ACCESS | memory addressed: load captured, direct store written, or RMW read
// WRITE  | merged word written back with a full-word write
// RESP   | response presented until rsp_ready
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int AW   = 6,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic [AW-1:0]   dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic            dm_we,
    output logic [1:0]      dm_mode,
    input  logic [XLEN-1:0] dm_rdata
);

    lsu_state_t      state, state_nx;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] merge_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;
    logic [AW-1:0]   addr_q;

    logic [1:0]      size_in;
    logic            fault_in;
    logic            direct_store;
    logic [XLEN-1:0] align_word;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    assign size_in  = norm_size(req_size);
    assign fault_in = ((size_in == SIZE_H) && req_addr[0])
                    || ((size_in == SIZE_W) && (req_addr[1:0] != 2'b00))
                    || (req_addr[XLEN-1:AW+2] != '0);

    // A store at offset 0 (or a full word) maps directly onto a memory mode.
    assign direct_store = (r_size == SIZE_W) || (r_off == 2'b00);
    assign align_word   = (state == WRITE) ? merge_q : dm_rdata;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size      (r_size),
        .offset    (r_off),
        .is_signed (r_signed),
        .word      (align_word),
        .wdata     (r_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            r_we     <= 1'b0;
            r_size   <= SIZE_B;
            r_signed <= 1'b0;
            r_off    <= 2'b00;
            r_wdata  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= size_in;
                        r_signed <= req_signed;
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        rdata_q  <= '0;
                        fault_q  <= fault_in;
                        if (!fault_in)
                            addr_q <= req_addr[AW+1:2];
                    end
                end
                ACCESS: begin
                    if (!r_we)
                        rdata_q <= load_data;
                    else
                        merge_q <= dm_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        dm_we     = 1'b0;
        dm_mode   = DM_MODE_WORD;
        dm_wdata  = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nx = fault_in ? RESP : ACCESS;
            end
            ACCESS: begin
                if (r_we && direct_store) begin
                    dm_we    = 1'b1;
                    dm_mode  = size_to_mode(r_size);
                    dm_wdata = r_wdata;
                    state_nx = RESP;
                end else if (r_we) begin
                    state_nx = WRITE;
                end else begin
                    state_nx = RESP;
                end
            end
            WRITE: begin
                dm_we    = 1'b1;
                dm_mode  = DM_MODE_WORD;
                dm_wdata = merged;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gated by clr so every output reads 0 while reset is held.
    assign req_ready = (state == IDLE) && !clr;
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
    assign dm_addr   = addr_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed vector table, hand-written
// hold/reset sequences, and random traffic against a byte-array model.
module tb_dm_lsu;

    localparam int AW   = 6;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            clr;
    logic            req_valid, req_ready, req_we, req_signed;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            rsp_valid, rsp_ready, rsp_fault;
    logic [XLEN-1:0] rsp_rdata;
    logic [AW-1:0]   dm_addr;
    logic [XLEN-1:0] dm_wdata, dm_rdata;
    logic            dm_we;
    logic [1:0]      dm_mode;

    dm_lsu #(.AW(AW), .XLEN(XLEN)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_mode(dm_mode), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Data memory behind the port: sub-word modes write only the low lane.
    logic [31:0] mem [64];
    logic        mem_init;
    assign dm_rdata = mem[dm_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 3) ? 32'h8899AABB : 32'h0;
        end else if (dm_we) begin
            case (dm_mode)
                2'b00:   mem[dm_addr]       <= dm_wdata;
                2'b01:   mem[dm_addr][15:0] <= dm_wdata[15:0];
                2'b10:   mem[dm_addr][7:0]  <= dm_wdata[7:0];
                default: ;
            endcase
        end
    end

    int wr_count = 0;
    int mode_err = 0;
    always @(negedge clk) begin
        if (!clr) begin
            if (dm_we) wr_count <= wr_count + 1;
            else if (dm_mode != 2'b00) mode_err <= mode_err + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: memory as 256 little-endian bytes.
    logic [7:0] ref_mem [256];

    task automatic ref_exec(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] e_rdata, output logic e_fault,
                            output int e_lat, output int e_wr);
        int nb;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e_rdata = 32'h0;
        e_fault = (addr >= 32'd256) || ((addr % nb) != 0);
        e_wr    = 0;
        if (e_fault) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            for (int b = 0; b < nb; b++)
                e_rdata[8*b +: 8] = ref_mem[addr[7:0] + b];
            if (sgn && nb < 4 && e_rdata[8*nb-1])
                for (int b = 8*nb; b < 32; b++) e_rdata[b] = 1'b1;
        end else begin
            e_wr  = 1;
            e_lat = (nb == 4 || addr[1:0] == 2'b00) ? 2 : 3;
            for (int b = 0; b < nb; b++)
                ref_mem[addr[7:0] + b] = wdata[8*b +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic fault,
                          output int lat, output int writes, output logic [5:0] idx);
        int guard;
        int w0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        w0         = wr_count;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        fault = rsp_fault;
        idx   = dm_addr;
        @(posedge clk); #1;
        writes = wr_count - w0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [31:0] got_rdata, e_rdata, held;
    logic        got_fault, e_fault;
    int          got_lat, got_wr, e_lat, e_wr, w_before, guard;
    logic [5:0]  got_idx;
    logic [31:0] word_exp;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_we, r_sgn;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0D,  32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
        vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0E,  32'h0,        32'h00008899, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0E,  32'h55,       32'h0,        1'b0, 3, 1};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0C,  32'h0,        32'h8855AABB, 1'b0, 2, 0};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h06,  32'h0,        32'h0,        1'b1, 1, 0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'h000000DE, 1'b0, 2, 0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h0C,  32'hFFFF1234, 32'h0,        1'b0, 2, 1};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0C,  32'h0,        32'h88551234, 1'b0, 2, 0};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h0F,  32'h1111,     32'h0,        1'b1, 1, 0};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h16,  32'hABCDCAFE, 32'h0,        1'b0, 3, 1};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hCAFE0000, 1'b0, 2, 0};
        vecs[15] = '{1'b1, 2'b00, 1'b0, 32'h17,  32'h12345677, 32'h0,        1'b0, 3, 1};
        vecs[16] = '{1'b0, 2'b00, 1'b1, 32'h17,  32'h0,        32'h00000077, 1'b0, 2, 0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[12] = 8'hBB; ref_mem[13] = 8'hAA; ref_mem[14] = 8'h99; ref_mem[15] = 8'h88;

        clr = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_fault", {31'b0, rsp_fault}, 32'h0);
        check("rst_dm_we", {31'b0, dm_we}, 32'h0);
        check("rst_dm_addr", {26'b0, dm_addr}, 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        check("rst_dm_mode", {30'b0, dm_mode}, 32'h0);
        mem_init = 1'b0;
        clr = 1'b0;
        #1;
        check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   got_rdata, got_fault, got_lat, got_wr, got_idx);
            ref_exec(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                     e_rdata, e_fault, e_lat, e_wr);
            check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_fault", i), {31'b0, got_fault}, {31'b0, vecs[i].exp_fault});
            check($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_writes", i), got_wr, vecs[i].exp_wr);
            if (!vecs[i].exp_fault)
                check($sformatf("vec%0d_dm_addr", i), {26'b0, got_idx}, {26'b0, vecs[i].addr[7:2]});
        end
        check("mem3_after_table", mem[3], 32'h88551234);
        check("mem4_after_table", mem[4], 32'hDEADBEEF);
        check("mem5_after_table", mem[5], 32'h77FE0000);

        // Response held off for 5 cycles: byte load of word 3 offset 0 (0x34).
        rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b1;
        req_addr = 32'h0C; req_wdata = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        check("hold_first_rdata", rsp_rdata, 32'h00000034);
        held = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_rsp_valid", c), {31'b0, rsp_valid}, 32'h1);
            check($sformatf("hold%0d_rsp_rdata", c), rsp_rdata, 32'h00000034);
            check($sformatf("hold%0d_req_ready", c), {31'b0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_req_ready", {31'b0, req_ready}, 32'h1);
        check("hold_release_rsp_valid", {31'b0, rsp_valid}, 32'h0);

        // Reset asserted while the RMW write-back is on the port.
        w_before = wr_count;
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0D; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_access_no_we", {31'b0, dm_we}, 32'h0);
        check("rmw_access_dm_addr", {26'b0, dm_addr}, 32'h3);
        @(posedge clk); #1;
        check("rmw_write_we", {31'b0, dm_we}, 32'h1);
        check("rmw_write_mode", {30'b0, dm_mode}, 32'h0);
        check("rmw_write_data", dm_wdata, 32'h88559934);
        clr = 1'b1;
        #1;
        check("clr_dm_we", {31'b0, dm_we}, 32'h0);
        check("clr_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("clr_dm_addr", {26'b0, dm_addr}, 32'h0);
        check("clr_dm_wdata", dm_wdata, 32'h0);
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        check("clr_idle_req_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        check("clr_no_write_pulse", wr_count - w_before, 32'h0);
        check("clr_mem3_unchanged", mem[3], 32'h88551234);

        for (int n = 0; n < 60; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_sgn  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) r_addr = $urandom;
            else r_addr = 32'($urandom_range(0, 255));
            req_wdata = $urandom;
            held = req_wdata;
            ref_exec(r_we, r_size, r_sgn, r_addr, held, e_rdata, e_fault, e_lat, e_wr);
            do_req(r_we, r_size, r_sgn, r_addr, held, got_rdata, got_fault, got_lat, got_wr, got_idx);
            check($sformatf("rnd%0d_rdata a=%h", n, r_addr), got_rdata, e_rdata);
            check($sformatf("rnd%0d_fault a=%h", n, r_addr), {31'b0, got_fault}, {31'b0, e_fault});
            check($sformatf("rnd%0d_latency", n), got_lat, e_lat);
            check($sformatf("rnd%0d_writes", n), got_wr, e_wr);
        end

        for (int w = 0; w < 64; w++) begin
            word_exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            check($sformatf("final_mem%0d", w), mem[w], word_exp);
        end
        check("dm_mode_zero_when_idle", mode_err, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
